rblwe_dec_ctrl: RTL and testbench

- Sequencer for the RBLWE decryption datapath, computing m = decode(c1*r2 + c2) over Z_256[x]/(x^N+1).
- Owns the coefficient load counter and the accumulator initialisation from c2.
- Schedules the negacyclic schoolbook multiply with zero-row skipping on binary r2, then the serial decode/output phase.
- Drives memory addresses and enables only; coefficient storage, MAC and threshold decode sit in the datapath alongside it under the RBLWE top.

---
 rtl/rblwe_pkg.sv | 20 ++
 rtl/rblwe_delay_line.sv | 28 ++
 rtl/rblwe_dec_ctrl.sv | 142 ++++++++++++++
 tb/tb_rblwe_dec_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rblwe_pkg.sv
// Shared constants and state encoding for the RBLWE decryption controller.
package rblwe_pkg;

    localparam int RBLWE_N       = 256;
    localparam int RBLWE_LOGN    = 8;
    localparam int RBLWE_OUT_LAT = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_TEST  = 3'd3;
    localparam logic [2:0] ST_ROW   = 3'd4;
    localparam logic [2:0] ST_OUT   = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    // Start edge to done pulse with every r2 bit set: INIT, N x (FETCH+TEST+ROW), OUT, DRAIN, DONE.
    localparam int RUN_CYCLES_MAX = RBLWE_N + RBLWE_N * (RBLWE_N + 2) + RBLWE_N + RBLWE_OUT_LAT + 1;

endpackage

// File: rtl/rblwe_delay_line.sv
// Fixed-depth shift register with synchronous reset; DEPTH must be at least 1.
module rblwe_delay_line
    import rblwe_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = RBLWE_OUT_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // NOTE: every stage is reset (this is a handful of flops, not a RAM) so an aborted run leaves no stale bits in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) pipe_q[s] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int s = 1; s < DEPTH; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/rblwe_dec_ctrl.sv
// Sequencer for RBLWE decryption: load addressing, acc init from c2, negacyclic
// schoolbook multiply with zero-row skipping on binary r2, then serial decode.
module rblwe_dec_ctrl
    import rblwe_pkg::*;
#(
    parameter int N       = RBLWE_N,
    parameter int LOGN    = RBLWE_LOGN,
    parameter int OUT_LAT = RBLWE_OUT_LAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            start,
    input  logic            r2_bit,
    output logic            mem_wr_en,
    output logic [LOGN-1:0] mem_wr_addr,
    output logic [LOGN-1:0] r2_rd_addr,
    output logic [LOGN-1:0] c1_rd_addr,
    output logic [LOGN-1:0] acc_addr,
    output logic            acc_init_en,
    output logic            mac_en,
    output logic            mac_neg,
    output logic            dec_en,
    output logic            valid,
    output logic            busy,
    output logic            done
);

    logic [2:0]      state_q, state_d;
    logic [LOGN-1:0] load_cnt_q, load_cnt_d;
    logic [LOGN-1:0] i_q, i_d;
    logic [LOGN-1:0] k_q, k_d;
    logic            start_d1_q;

    logic last_k, last_i, drain_last, start_edge;

    assign last_k     = (k_q == LOGN'(N - 1));
    assign last_i     = (i_q == LOGN'(N - 1));
    assign drain_last = (k_q == LOGN'(OUT_LAT - 1));
    assign start_edge = start & ~start_d1_q & ~load & (state_q == ST_IDLE);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        i_d        = i_q;
        k_d        = k_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d    = ST_INIT;
                    load_cnt_d = '0;
                    i_d        = '0;
                    k_d        = '0;
                end else if (load) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                k_d = last_k ? '0 : k_q + 1'b1;
                if (last_k) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_TEST;
            ST_TEST: begin
                if (r2_bit) begin
                    state_d = ST_ROW;
                end else if (last_i) begin
                    state_d = ST_OUT;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_ROW: begin
                k_d = last_k ? '0 : k_q + 1'b1;
                if (last_k) begin
                    if (last_i) begin
                        state_d = ST_OUT;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_OUT: begin
                k_d = last_k ? '0 : k_q + 1'b1;
                if (last_k) state_d = ST_DRAIN;
            end
            // k doubles as the drain counter; OUT_LAT never exceeds N.
            ST_DRAIN: begin
                k_d = drain_last ? '0 : k_q + 1'b1;
                if (drain_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                i_d     = '0;
                k_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            i_q        <= '0;
            k_q        <= '0;
            start_d1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            i_q        <= i_d;
            k_q        <= k_d;
            start_d1_q <= start;
        end
    end

    assign mem_wr_en   = load & ~reset & (state_q == ST_IDLE);
    assign mem_wr_addr = load_cnt_q;
    assign r2_rd_addr  = i_q;
    assign c1_rd_addr  = k_q - i_q;
    assign acc_addr    = k_q;
    assign acc_init_en = (state_q == ST_INIT);
    assign mac_en      = (state_q == ST_ROW);
    assign mac_neg     = mac_en & (k_q < i_q);
    assign dec_en      = (state_q == ST_OUT);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

    rblwe_delay_line #(
        .WIDTH (1),
        .DEPTH (OUT_LAT)
    ) u_valid_dly (
        .clk   (clk),
        .reset (reset),
        .d_i   (dec_en),
        .q_o   (valid)
    );

endmodule

// File: tb/tb_rblwe_dec_ctrl.sv
// Scoreboard bench for rblwe_dec_ctrl: a run-level model queues expected
// enable events with their cycle; a negedge monitor pops and compares.
module tb_rblwe_dec_ctrl;
    import rblwe_pkg::*;

    localparam int TN = RBLWE_N;
    localparam int TL = RBLWE_LOGN;
    localparam int TO = RBLWE_OUT_LAT;

    localparam int K_WR = 0, K_INIT = 1, K_MAC = 2, K_DEC = 3, K_VAL = 4, K_DONE = 5;

    logic          clk = 1'b0;
    logic          reset, load, start, r2_bit;
    logic          mem_wr_en, acc_init_en, mac_en, mac_neg, dec_en, valid, busy, done;
    logic [TL-1:0] mem_wr_addr, r2_rd_addr, c1_rd_addr, acc_addr;

    rblwe_dec_ctrl #(.N(TN), .LOGN(TL), .OUT_LAT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .start       (start),
        .r2_bit      (r2_bit),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .r2_rd_addr  (r2_rd_addr),
        .c1_rd_addr  (c1_rd_addr),
        .acc_addr    (acc_addr),
        .acc_init_en (acc_init_en),
        .mac_en      (mac_en),
        .mac_neg     (mac_neg),
        .dec_en      (dec_en),
        .valid       (valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read r2 memory standing in for the datapath.
    bit r2_mem [TN];
    always @(posedge clk) r2_bit <= r2_mem[r2_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int a;
        int b;
        int c;
    } ev_t;

    ev_t   exp_q [6][$];
    string kind_nm [6] = '{"wr", "init", "mac", "dec", "valid", "done"};
    int    checks = 0;
    int    errors = 0;
    int    busy_lo = -1;
    int    busy_hi = -2;
    int    load_cnt_m = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int kind, input int c, input int a, input int b, input int n);
        ev_t e;
        e.cyc = c;
        e.a   = a;
        e.b   = b;
        e.c   = n;
        exp_q[kind].push_back(e);
    endfunction

    function automatic int pending();
        int n = 0;
        for (int q = 0; q < 6; q++) n += exp_q[q].size();
        return n;
    endfunction

    // Reference schedule of a whole run, start edge in cycle s; returns the done cycle.
    function automatic int push_run(input int s, input bit [TN-1:0] bits);
        int t = s + 1;
        for (int k = 0; k < TN; k++) begin
            push(K_INIT, t, k, 0, 0);
            t++;
        end
        for (int i = 0; i < TN; i++) begin
            t += 2;
            if (bits[i]) begin
                for (int k = 0; k < TN; k++) begin
                    push(K_MAC, t, k, (k - i + TN) % TN, (k < i) ? 1 : 0);
                    t++;
                end
            end
        end
        for (int k = 0; k < TN; k++) begin
            push(K_DEC, t, k, 0, 0);
            push(K_VAL, t + TO, 0, 0, 0);
            t++;
        end
        t += TO;
        push(K_DONE, t, 0, 0, 0);
        busy_lo = s + 1;
        busy_hi = t;
        return t;
    endfunction

    task automatic take(input int kind, input int a, input int b, input int c);
        ev_t e;
        if (exp_q[kind].size() == 0) begin
            check({kind_nm[kind], " unexpected"}, 1, 0);
        end else begin
            e = exp_q[kind].pop_front();
            check({kind_nm[kind], " cycle"}, cyc, e.cyc);
            if (kind <= K_DEC) check({kind_nm[kind], " addr"}, a, e.a);
            if (kind == K_MAC) begin
                check("mac c1_rd_addr", b, e.b);
                check("mac_neg", c, e.c);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mem_wr_en)   take(K_WR, mem_wr_addr, 0, 0);
            if (acc_init_en) take(K_INIT, acc_addr, 0, 0);
            if (mac_en)      take(K_MAC, acc_addr, c1_rd_addr, mac_neg);
            if (dec_en)      take(K_DEC, acc_addr, 0, 0);
            if (valid)       take(K_VAL, 0, 0, 0);
            if (done)        take(K_DONE, 0, 0, 0);
            check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int n);
        repeat (n) begin
            load = 1'b1;
            push(K_WR, cyc, load_cnt_m, 0, 0);
            load_cnt_m = (load_cnt_m + 1) % TN;
            tick();
        end
        load = 1'b0;
    endtask

    // hold < 0 keeps start high until two cycles after done.
    task automatic run(input bit [TN-1:0] bits, input int hold, input bit busy_load);
        int s, e, h;
        for (int i = 0; i < TN; i++) r2_mem[i] = bits[i];
        start = 1'b1;
        s = cyc;
        e = push_run(s, bits);
        load_cnt_m = 0;
        h = (hold < 0) ? (e - s + 3) : hold;
        repeat (h) tick();
        start = 1'b0;
        if (busy_load) begin
            load = 1'b1;
            repeat (3) tick();
            load = 1'b0;
        end
        while (cyc < e + 3) tick();
        repeat (3) tick();
        check("events left after run", pending(), 0);
    endtask

    task automatic sparse_bits(output bit [TN-1:0] bits);
        bits = '0;
        repeat ($urandom_range(1, 4)) bits[$urandom_range(0, TN - 1)] = 1'b1;
    endtask

    task automatic reset_mid_row();
        bit [TN-1:0] bits;
        int s;
        bits = '0;
        bits[5] = 1'b1;
        bits[9] = 1'b1;
        for (int i = 0; i < TN; i++) r2_mem[i] = bits[i];
        start = 1'b1;
        s = cyc;
        void'(push_run(s, bits));
        load_cnt_m = 0;
        tick();
        start = 1'b0;
        while (cyc < s + TN + 30) tick();
        check("mid-row acc_addr", acc_addr, 17);
        check("mid-row r2_rd_addr", r2_rd_addr, 5);
        reset = 1'b1;
        for (int q = 0; q < 6; q++) exp_q[q].delete();
        busy_lo = -1;
        busy_hi = -2;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("outputs after mid-run reset",
              {mem_wr_en, mem_wr_addr, r2_rd_addr, c1_rd_addr, acc_addr,
               acc_init_en, mac_en, mac_neg, dec_en, valid, busy, done}, 0);
        tick();
    endtask

    initial begin
        #(99_000 * 10);
        $display("FAIL watchdog expired at cycle %0d, %0d events pending", cyc, pending());
        $fatal(1);
    end

    initial begin
        bit [TN-1:0] bits;
        reset = 1'b1;
        load  = 1'b0;
        start = 1'b0;
        for (int i = 0; i < TN; i++) r2_mem[i] = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("outputs after reset",
              {mem_wr_en, mem_wr_addr, r2_rd_addr, c1_rd_addr, acc_addr,
               acc_init_en, mac_en, mac_neg, dec_en, valid, busy, done}, 0);
        tick();

        // Full load plus one wrap, then a start edge that collides with load.
        do_load(TN + 1);
        load  = 1'b1;
        start = 1'b1;
        push(K_WR, cyc, load_cnt_m, 0, 0);
        load_cnt_m = (load_cnt_m + 1) % TN;
        tick();
        load = 1'b0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("events left after dropped start", pending(), 0);

        // r2 all zero, short start pulse, load attempts while busy.
        run('0, 2, 1'b1);
        do_load(10);

        bits = '0;
        bits[1] = 1'b1;
        run(bits, 1, 1'b0);

        repeat (3) begin
            sparse_bits(bits);
            run(bits, 1, 1'b0);
        end

        // Boundary rows, start held through completion.
        bits = '0;
        bits[0] = 1'b1;
        bits[TN-1] = 1'b1;
        run(bits, -1, 1'b0);

        reset_mid_row();
        do_load(TN);
        sparse_bits(bits);
        run(bits, 1, 1'b0);

        // Worst case: every row multiplied.
        run('1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
